// File: rtl/word_tx_serializer_pkg.sv
// Shared definitions for the word serializer: default widths and FSM encoding.
package word_tx_serializer_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned ByteWDef = 8;
  localparam int unsigned DepthDef = 4;

  // FSM encoding kept as plain constants so legacy debug-unit code can share it.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  // Part index width; never below one bit even for a single-part word.
  function automatic int unsigned idx_width(input int unsigned nparts);
    return (nparts > 1) ? $clog2(nparts) : 1;
  endfunction

endpackage

// File: rtl/word_tx_serializer_if.sv
// Bus between the debug unit / UART transmitter side and the serializer.
interface word_tx_serializer_if #(
  parameter int unsigned DATA_W = word_tx_serializer_pkg::DataWDef,
  parameter int unsigned BYTE_W = word_tx_serializer_pkg::ByteWDef,
  parameter int unsigned DEPTH  = word_tx_serializer_pkg::DepthDef
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DATA_W-1:0] entrada;
  logic              enviar;
  logic              tx_done_tick;
  logic              tx_start;
  logic [BYTE_W-1:0] parte;
  logic              done;
  logic              busy;
  logic              full;
  logic              empty;
  logic [CntW-1:0]   count;
  logic              overflow;

  modport master (
    output wr, entrada, enviar, tx_done_tick,
    input  tx_start, parte, done, busy, full, empty, count, overflow
  );

  modport slave (
    input  wr, entrada, enviar, tx_done_tick,
    output tx_start, parte, done, busy, full, empty, count, overflow
  );

endinterface

// File: rtl/word_tx_serializer_sync_fifo.sv
// Circular word FIFO with occupancy count and sticky overflow flag.
module word_tx_serializer_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q;
  logic              do_rd, do_wr;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign dout_o     = mem_q[rptr_q];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_rd = rd_i && !empty_o;
  assign do_wr = wr_i && (!full_o || do_rd);

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and sticky overflow; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PtrW'(1);
      if (do_rd) rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
      if (wr_i && !do_wr) overflow_q <= 1'b1;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/word_tx_serializer.sv
// Splits queued words into BYTE_W parts and hands them to the UART tx one at a time.
module word_tx_serializer
  import word_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned BYTE_W    = ByteWDef,
  parameter int unsigned DEPTH     = DepthDef,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                 clk_i,
  input logic                 reset_i,
  word_tx_serializer_if.slave bus_io
);

  localparam int unsigned NParts = DATA_W / BYTE_W;
  localparam int unsigned IdxW   = idx_width(NParts);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0] parte_q, parte_d;
  logic              done_q, done_d;
  logic              fifo_rd, fifo_empty, load_word;
  logic [DATA_W-1:0] fifo_dout;

  word_tx_serializer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_i       (bus_io.wr),
    .rd_i       (fifo_rd),
    .din_i      (bus_io.entrada),
    .dout_o     (fifo_dout),
    .full_o     (bus_io.full),
    .empty_o    (fifo_empty),
    .count_o    (bus_io.count),
    .overflow_o (bus_io.overflow)
  );

  assign bus_io.empty    = fifo_empty;
  assign bus_io.tx_start = (state_q == StStart);
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.parte    = parte_q;
  assign bus_io.done     = done_q;

  // Part that goes out next from a word, in the configured order.
  function automatic logic [BYTE_W-1:0] first_part(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

  // Word with the part just taken removed, so the next part is at the output end.
  function automatic logic [DATA_W-1:0] drop_part(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << BYTE_W) : (w >> BYTE_W);
  endfunction

  // FSM next-state, part sequencing and pop decision.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    parte_d   = parte_q;
    done_d    = 1'b0;
    fifo_rd   = 1'b0;
    load_word = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.enviar && !fifo_empty) load_word = 1'b1;
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (bus_io.tx_done_tick) begin
          if (idx_q != IdxW'(NParts - 1)) begin
            idx_d   = idx_q + IdxW'(1);
            parte_d = first_part(shreg_q);
            shreg_d = drop_part(shreg_q);
            state_d = StStart;
          end else if (bus_io.enviar && !fifo_empty) begin
            load_word = 1'b1;
          end else begin
            // Stopped with words still queued is not a drain, so no done.
            state_d = StIdle;
            done_d  = fifo_empty;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_word) begin
      fifo_rd = 1'b1;
      idx_d   = '0;
      parte_d = first_part(fifo_dout);
      shreg_d = drop_part(fifo_dout);
      state_d = StStart;
    end
  end

  // Registered FSM state, shift register and outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      idx_q   <= '0;
      parte_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      parte_q <= parte_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_word_tx_serializer.sv
// Scoreboard bench: two DUTs (MSB-first and LSB-first) share stimulus; each has
// its own transmitter model and monitor checking parts against the word list.
module tb_word_tx_serializer;
  import word_tx_serializer_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned DP = 4;
  localparam int NP = DW / BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr, enviar;
  logic [DW-1:0] entrada;
  logic [1:0]    tick_r;

  always #5 clk = ~clk;

  word_tx_serializer_if #(.DATA_W(DW), .BYTE_W(BW), .DEPTH(DP)) bus_m ();
  word_tx_serializer_if #(.DATA_W(DW), .BYTE_W(BW), .DEPTH(DP)) bus_l ();

  assign bus_m.wr = wr;
  assign bus_m.entrada = entrada;
  assign bus_m.enviar = enviar;
  assign bus_m.tx_done_tick = tick_r[0];
  assign bus_l.wr = wr;
  assign bus_l.entrada = entrada;
  assign bus_l.enviar = enviar;
  assign bus_l.tx_done_tick = tick_r[1];

  word_tx_serializer #(.DATA_W(DW), .BYTE_W(BW), .DEPTH(DP), .MSB_FIRST(1'b1)) u_dut_m (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus_m)
  );

  word_tx_serializer #(.DATA_W(DW), .BYTE_W(BW), .DEPTH(DP), .MSB_FIRST(1'b0)) u_dut_l (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus_l)
  );

  logic [1:0]    st_w, dn_w, busy_w, full_w, empty_w, ovf_w;
  logic [BW-1:0] pt_w  [2];
  logic [2:0]    cnt_w [2];

  assign st_w    = {bus_l.tx_start, bus_m.tx_start};
  assign dn_w    = {bus_l.done, bus_m.done};
  assign busy_w  = {bus_l.busy, bus_m.busy};
  assign full_w  = {bus_l.full, bus_m.full};
  assign empty_w = {bus_l.empty, bus_m.empty};
  assign ovf_w   = {bus_l.overflow, bus_m.overflow};
  assign pt_w[0] = bus_m.parte;
  assign pt_w[1] = bus_l.parte;
  assign cnt_w[0] = bus_m.count;
  assign cnt_w[1] = bus_l.count;

  int errors = 0;
  int checks = 0;

  // Accepted words in push order; each channel walks it with its own index.
  logic [DW-1:0] words[$];
  int tick_dly = 10;
  bit rnd_dly = 1'b0;

  int widx[2], pk[2], cdn[2];
  bit pend[2], exp_done[2], exp_st_chk[2], exp_st[2];
  logic [BW-1:0] lat[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [BW-1:0] exp_part(input logic [DW-1:0] w, input int k, input bit msb);
    return msb ? w[DW-1-k*BW -: BW] : w[k*BW +: BW];
  endfunction

  // Transmitter model plus monitor, one pass per channel on the falling edge.
  always @(negedge clk) begin
    int committed;
    if (reset) begin
      tick_r = 2'b00;
      for (int c = 0; c < 2; c++) begin
        widx[c] = 0; pk[c] = 0; pend[c] = 0;
        exp_done[c] = 0; exp_st_chk[c] = 0; exp_st[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        tick_r[c] = 1'b0;
        chk($sformatf("ch%0d done", c), {31'd0, dn_w[c]}, {31'd0, exp_done[c]});
        exp_done[c] = 1'b0;
        if (exp_st_chk[c]) begin
          chk($sformatf("ch%0d start after tick", c), {31'd0, st_w[c]}, {31'd0, exp_st[c]});
          exp_st_chk[c] = 1'b0;
        end
        if (st_w[c]) begin
          if (pend[c]) fail($sformatf("ch%0d tx_start while waiting for tick", c));
          else if (widx[c] >= words.size()) fail($sformatf("ch%0d tx_start with no word queued", c));
          else begin
            chk($sformatf("ch%0d part w%0d k%0d", c, widx[c], pk[c]), {24'd0, pt_w[c]},
                {24'd0, exp_part(words[widx[c]], pk[c], (c == 0))});
            lat[c]  = pt_w[c];
            pend[c] = 1'b1;
            cdn[c]  = rnd_dly ? int'($urandom_range(1, 5)) : tick_dly;
          end
        end else if (pend[c]) begin
          chk($sformatf("ch%0d parte stable", c), {24'd0, pt_w[c]}, {24'd0, lat[c]});
          cdn[c]--;
          if (cdn[c] == 0) begin
            tick_r[c] = 1'b1;
            pend[c]   = 1'b0;
            exp_st_chk[c] = 1'b1;
            committed = words.size();
            if (pk[c] != NP - 1) begin
              pk[c]++;
              exp_st[c] = 1'b1;
            end else begin
              pk[c] = 0;
              widx[c]++;
              exp_st[c]   = enviar && (committed > widx[c]);
              exp_done[c] = (committed == widx[c]);
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] w, input bit accept);
    wr = 1'b1;
    entrada = w;
    @(posedge clk); #1;
    if (accept) words.push_back(w);
    wr = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (widx[0] == words.size() && widx[1] == words.size() && !pend[0] && !pend[1] &&
          busy_w == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail({name, " drain timeout"});
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_part(input int k, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (pend[0] && pk[0] == k) begin ok = 1'b1; break; end
    end
    if (!ok) fail({name, " wait for part timeout"});
  endtask

  task automatic check_reset_vals(input string name);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s ch%0d tx_start", name, c), {31'd0, st_w[c]}, 0);
      chk($sformatf("%s ch%0d done", name, c), {31'd0, dn_w[c]}, 0);
      chk($sformatf("%s ch%0d busy", name, c), {31'd0, busy_w[c]}, 0);
      chk($sformatf("%s ch%0d full", name, c), {31'd0, full_w[c]}, 0);
      chk($sformatf("%s ch%0d empty", name, c), {31'd0, empty_w[c]}, 1);
      chk($sformatf("%s ch%0d count", name, c), {29'd0, cnt_w[c]}, 0);
      chk($sformatf("%s ch%0d overflow", name, c), {31'd0, ovf_w[c]}, 0);
      chk($sformatf("%s ch%0d parte", name, c), {24'd0, pt_w[c]}, 0);
    end
  endtask

  initial begin
    int sent;
    reset = 1'b1; wr = 1'b0; enviar = 1'b0; entrada = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Single words, fixed 10-cycle transmitter latency.
    @(posedge clk); #1;
    enviar = 1'b1;
    push(32'hFF00FF00, 1'b1);
    drain("word FF00FF00");
    push(32'hF0F0FF18, 1'b1);
    drain("word F0F0FF18");

    // Three back-to-back words: continuous stream, one done at the end.
    push(32'h11223344, 1'b1);
    push(32'h55667788, 1'b1);
    push(32'h99AABBCC, 1'b1);
    drain("three words");

    // Overflow: fill with sending disabled, fifth push dropped.
    enviar = 1'b0;
    for (int i = 0; i < DP; i++) push(32'hA0A0_0000 + i, 1'b1);
    push(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("ovf ch%0d full", c), {31'd0, full_w[c]}, 1);
      chk($sformatf("ovf ch%0d count", c), {29'd0, cnt_w[c]}, DP);
      chk($sformatf("ovf ch%0d overflow", c), {31'd0, ovf_w[c]}, 1);
      chk($sformatf("ovf ch%0d empty", c), {31'd0, empty_w[c]}, 0);
      chk($sformatf("ovf ch%0d busy", c), {31'd0, busy_w[c]}, 0);
    end
    @(posedge clk); #1;
    enviar = 1'b1;
    drain("overflow drain");

    // Drop enviar during part 2 of word 1 with word 2 queued.
    push(32'h0BADF00D, 1'b1);
    push(32'hCAFE1234, 1'b1);
    wait_part(1, "enviar drop");
    enviar = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("pause ch%0d busy", c), {31'd0, busy_w[c]}, 0);
      chk($sformatf("pause ch%0d count", c), {29'd0, cnt_w[c]}, 1);
    end
    @(posedge clk); #1;
    enviar = 1'b1;
    drain("resume");

    // Reset during the wait of part 3.
    push(32'h12345678, 1'b1);
    wait_part(2, "reset mid-word");
    reset = 1'b1;
    words.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid reset");
    @(posedge clk); #1;
    push(32'h87654321, 1'b1);
    drain("after reset");

    // Random traffic with random transmitter latency and enviar toggling.
    rnd_dly = 1'b1;
    sent = 0;
    for (int i = 0; i < 3000 && sent < 20; i++) begin
      if ($urandom_range(0, 7) == 0) enviar = ~enviar;
      if (full_w == 2'b00 && $urandom_range(0, 2) == 0) begin
        push($urandom, 1'b1);
        sent++;
      end else begin
        @(posedge clk); #1;
      end
    end
    enviar = 1'b1;
    drain("random");

    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("end ch%0d count", c), {29'd0, cnt_w[c]}, 0);
      chk($sformatf("end ch%0d empty", c), {31'd0, empty_w[c]}, 1);
      chk($sformatf("end ch%0d overflow", c), {31'd0, ovf_w[c]}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_tx_serializer.md
# word_tx_serializer

Parametrised successor of the debug-unit instruction splitter: accepts whole words (instructions, register or memory dumps) into a small FIFO and serialises each into BYTE_W-wide parts for the UART transmitter. It handshakes byte-by-byte with the transmitter (tx_start out, tx_done_tick in), offers selectable byte order, and reports drain completion and overflow. It sits between the MIPS debug unit and the UART tx.

## Interface
- DATA_W, 32: word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8: part width sent per transmitter frame.
- DEPTH, 4: FIFO depth in words; power of two, at least 2.
- MSB_FIRST, 1: 1 sends the most-significant part first; 0 sends the least-significant part first.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  push entrada into FIFO this cycle.
- entrada  in  DATA_W  word to enqueue.
- enviar  in  1  transmission enable; words are popped only while high.
- tx_done_tick  in  1  one-cycle pulse from transmitter: current part sent.
- tx_start  out  1  one-cycle pulse: transmitter loads parte.
- parte  out  BYTE_W  current part; stable from tx_start until the matching tx_done_tick.
- done  out  1  one-cycle pulse: last part of last queued word acknowledged, FIFO empty.
- busy  out  1  high while a word is being serialised.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds no words.
- count  out  $clog2(DEPTH)+1  words in FIFO (excludes the word being serialised).
- overflow  out  1  sticky: a push was dropped; cleared only by reset.

## Operation
- NPARTS = DATA_W/BYTE_W; part index width $clog2(NPARTS), minimum 1.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH. A push while full is dropped and sets overflow, except when a pop occurs in the same cycle, in which case the push is accepted. A push while empty is never popped in the same cycle.
- FSM states:
  - IDLE: busy=0. If enviar && !empty: pop head word into shift register, idx=0, load parte with the first part, go to START.
  - START: tx_start=1 for exactly this cycle, go to WAIT. A tx_done_tick seen in START is ignored.
  - WAIT: hold parte and wait for tx_done_tick.
    - Tick with idx<NPARTS-1: idx+1, shift the next part into parte, go to START.
    - Tick with idx==NPARTS-1 and enviar && !empty: pop the next word immediately, go to START with no IDLE cycle.
    - Tick with idx==NPARTS-1 and empty: pulse done, go to IDLE.
    - Tick with idx==NPARTS-1, !empty but !enviar: go to IDLE, no done.
- Dropping enviar mid-word does not abort the word; it only stops further pops.
- Part order: with MSB_FIRST=1, part k = entrada[DATA_W-1-k*BYTE_W -: BYTE_W]; with MSB_FIRST=0, part k = entrada[k*BYTE_W +: BYTE_W].

## Timing
- Reset values: state IDLE, pointers and count 0, empty=1, full=0, tx_start=0, done=0, busy=0, overflow=0, parte=0. Reset mid-word discards the FIFO and the shift register; no done pulse is produced.
- Push at edge k: count and empty/full update after edge k. A word is eligible for pop at edge k+1 at the earliest.
- Pop at edge k: tx_start is high during cycle k+1, and parte is valid from cycle k+1.
- tx_done_tick at edge m (not the last part): tx_start is high during cycle m+1 with the next part.
- Last tick at edge m with the FIFO empty: done is high during cycle m+1, busy falls after edge m.
- Minimum spacing between tx_start pulses is 2 cycles, or 1 cycle after the tick.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.

## Structure
- Shared debug package holds BYTE_W default, DATA_W default, and the state encoding (IDLE/START/WAIT).
- One sub-module: sync_fifo (parametrised DATA_W, DEPTH; wr, rd, full, empty, count, dout, overflow logic). The FSM and the shift/select logic live in the top module.

## Test plan
- Defaults, push 32'hFF00FF00, enviar=1, tick 10 cycles after each tx_start -> parte sequence FF,00,FF,00; 4 tx_start pulses; one done pulse after the 4th tick.
- MSB_FIRST=0, push 32'hF0F0FF18 -> parte sequence 18,FF,F0,F0.
- Push 3 words back-to-back with enviar=1 -> 12 parts in order, no IDLE between words, single done after part 12, count goes 1→2→… and back to 0.
- enviar=0, push DEPTH+1 words -> full=1, count=4, overflow=1; first 4 words later sent intact.
- Drop enviar during part 2 of word 1 with word 2 queued -> word 1 completes, no done, word 2 starts when enviar returns.
- Assert reset during WAIT of part 3 -> all outputs at reset values next cycle; a subsequent push is sent from part 0.
